fp_mult_arbiter: RTL and testbench
==================================

// Module: fp_mult_arbiter
// PURPOSE
//   Shares one 12-bit floating-point multiplier (1 sign, 5 exp, 6 frac, bias 15)
//   among NUM_REQ requesters. Uses round-robin arbitration and valid/ready handshakes.
//   Tags each issued operation through the multiplier pipeline.
//   Returns each result to its originating requester in a held response register.
//   Sits between the multiplier and the vector/accumulator front-ends.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..8)
//   DATA_W    12  operand/result width
//   MULT_LAT  1   cycles from mult_valid_in to mult_valid_out (1..4)
// PORTS
//   clk            in   1               single clock, rising edge
//   rst_n          in   1               async active-low reset
//   req_valid      in   NUM_REQ         per-requester operand valid
//   req_a          in   NUM_REQ*DATA_W  operand A, requester i at [i*DATA_W +: DATA_W]
//   req_b          in   NUM_REQ*DATA_W  operand B, same packing
//   req_ready      out  NUM_REQ         one-hot grant; handshake = valid&ready
//   resp_valid     out  NUM_REQ         result held for requester i
//   resp_result    out  NUM_REQ*DATA_W  per-requester result, same packing
//   resp_ready     in   NUM_REQ         requester consumes result
//   mult_a         out  DATA_W          to multiplier a
//   mult_b         out  DATA_W          to multiplier b
//   mult_valid_in  out  1               to multiplier valid_in
//   mult_result    in   DATA_W          from multiplier result
//   mult_valid_out in   1               from multiplier valid_out
//   err_seq        out  1               sticky: mult_valid_out with no tag in flight
//   grant_cnt      out  16              grants issued (see CONFIGURATION)
// BEHAVIOUR
//   Reset:
//   - All outputs 0; rr pointer = 0; pending, tags and response registers cleared.
//   - Reset mid-operation discards in-flight tags and held results.
//   Eligibility:
//   - Requester i is eligible when req_valid[i] && !pending[i].
//   - pending[i] is set on grant. It is cleared on the cycle after resp_valid[i] && resp_ready[i].
//   - Each requester has at most one operation outstanding.
//   Arbitration (combinational, same cycle):
//   - Search eligible requesters starting at rr pointer, wrapping modulo NUM_REQ.
//   - The first eligible requester g gets req_ready[g] = 1.
//   - Same cycle: mult_a = req_a[g], mult_b = req_b[g], mult_valid_in = 1.
//   - No eligible requester: req_ready = 0, mult_valid_in = 0, mult_a/b = 0.
//   - After a grant, rr pointer <= (g+1) mod NUM_REQ. Otherwise it is unchanged.
//   - Back-to-back grants on consecutive cycles are allowed; throughput is 1 op/cycle.
//   Tag pipe:
//   - Shift register MULT_LAT deep of {valid, id}; stage 0 loads {grant, g} each cycle.
//   - When mult_valid_out && tail.valid: resp_result[id] <= mult_result and resp_valid[id] <= 1.
//     The response appears 1 cycle after mult_valid_out.
//   - Total latency from grant to resp_valid is MULT_LAT+1 cycles.
//   - mult_valid_out with tail.valid = 0: result dropped, err_seq <= 1 (cleared only by reset).
//   - tail.valid && !mult_valid_out: result dropped, err_seq <= 1, pending[id] cleared.
//   Response:
//   - resp_valid[i] stays high, with resp_result[i] stable, until resp_ready[i].
//   - It cannot be overwritten, because pending[i] blocks re-grant.
//   Simultaneous events:
//   - Response accepted and req_valid in the same cycle: no grant to i that cycle.
//     It becomes eligible the next cycle.
//   - Multiple results never target the same id.
//   Arithmetic:
//   - The block passes operands and results through unmodified.
//   - Zero, underflow and saturation (0x7B0) behaviour belongs to the multiplier.
// CONFIGURATION
//   FPM_ARB_STATS_EN defined:
//   - grant_cnt increments on every grant and saturates at 16'hFFFF.
//   - It resets to 0.
//   FPM_ARB_STATS_EN undefined:
//   - grant_cnt is tied to 16'h0000 and the counter logic is absent.
// TESTING
//   1. Req0 a=0x3E0 (1.5), b=0x400 (2.0), cycle 0 -> req_ready[0]=1 cycle 0;
//      resp_valid[0]=1 at cycle MULT_LAT+1 with result 0x420 (3.0).
//   2. Req0..3 all valid at once, each 0x3C0*0x3C0 -> grants 0,1,2,3 on consecutive cycles;
//      each resp_result = 0x3C0.
//   3. Req1 holds resp_ready=0 while req_valid[1] stays 1 -> no second grant to 1;
//      other requesters keep being served; grant to 1 resumes the cycle after resp_ready.
//   4. Req2 a=0x000, b=0x3C0 -> result 0x000.
//      Req2 a=0x7C0, b=0x7C0 -> result 0x7B0 (saturation passed through).
//   5. Assert rst_n=0 with 3 ops in flight -> all outputs 0 asynchronously;
//      after release, no stale resp_valid and err_seq = 0.
//   6. Force mult_valid_out=1 with no grant outstanding -> err_seq=1 sticky; no resp_valid.
//      With FPM_ARB_STATS_EN, after 5 grants grant_cnt = 5.

Source files
------------

// File: rtl/fp_mult_arbiter_if.sv
// Handshake bundle between the fp_mult_arbiter, its requesters and the shared
// 12-bit floating-point multiplier. The slave modport is the arbiter's view,
// and the master modport is the view of the environment (requesters plus multiplier).
interface fp_mult_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 12
);
  // Requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_a;
  logic [NUM_REQ*DATA_W-1:0] req_b;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ*DATA_W-1:0] resp_result;
  logic [NUM_REQ-1:0]        resp_ready;
  // Multiplier side
  logic [DATA_W-1:0]         mult_a;
  logic [DATA_W-1:0]         mult_b;
  logic                      mult_valid_in;
  logic [DATA_W-1:0]         mult_result;
  logic                      mult_valid_out;

  modport slave (
    input  req_valid, req_a, req_b, resp_ready, mult_result, mult_valid_out,
    output req_ready, resp_valid, resp_result, mult_a, mult_b, mult_valid_in
  );

  modport master (
    output req_valid, req_a, req_b, resp_ready, mult_result, mult_valid_out,
    input  req_ready, resp_valid, resp_result, mult_a, mult_b, mult_valid_in
  );
endinterface

// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter: shares one pipelined 12-bit FP multiplier among NUM_REQ
// requesters with round-robin arbitration. Each issued operation carries a tag
// {valid, id} through a MULT_LAT-deep shadow pipe so the returning result can be
// parked in the originating requester's held response register.
// Operands and results pass through unmodified.
// Optional feature: define FPM_ARB_STATS_EN to build the saturating 16-bit
// grant counter on grant_cnt_o; otherwise grant_cnt_o is tied to zero.
module fp_mult_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 12,
  parameter int MULT_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fp_mult_arbiter_if.slave            bus_io,
  output logic                        err_seq_o,
  output logic [15:0]                 grant_cnt_o
);

  localparam int IDW = $clog2(NUM_REQ);

  // Control state
  logic [IDW-1:0]            rr_q, rr_d;
  logic [NUM_REQ-1:0]        pending_q, pending_d;
  logic [NUM_REQ-1:0]        resp_vld_q, resp_vld_d;
  logic [NUM_REQ*DATA_W-1:0] resp_res_q, resp_res_d;
  logic                      err_q, err_d;

  // Tag pipe mirroring the multiplier latency
  logic                      tag_vld_q [MULT_LAT];
  logic [IDW-1:0]            tag_id_q  [MULT_LAT];
  logic                      tail_vld;
  logic [IDW-1:0]            tail_id;

  // Arbitration results
  logic [NUM_REQ-1:0]        elig;
  logic                      grant_vld;
  logic [IDW-1:0]            grant_id;
  logic [NUM_REQ-1:0]        grant_oh;
  logic [IDW:0]              arb_sum;
  logic [IDW-1:0]            arb_idx;
  logic [NUM_REQ-1:0]        accept;

  // Reset also masks eligibility so req_ready/mult_* drop to zero the moment rst_n falls.
  assign elig = bus_io.req_valid & ~pending_q & {NUM_REQ{rst_n}};

  assign tail_vld = tag_vld_q[MULT_LAT-1];
  assign tail_id  = tag_id_q[MULT_LAT-1];

  // Round-robin search: scan from the farthest offset down so the nearest eligible
  // requester to rr_q is the last writer and wins.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    arb_sum   = '0;
    arb_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      arb_sum = {1'b0, rr_q} + (IDW+1)'(k);
      if (arb_sum >= (IDW+1)'(NUM_REQ)) begin
        arb_sum = arb_sum - (IDW+1)'(NUM_REQ);
      end
      arb_idx = arb_sum[IDW-1:0];
      if (elig[arb_idx]) begin
        grant_vld = 1'b1;
        grant_id  = arb_idx;
      end
    end
  end

  // Drive the grant and steer the winner's operands onto the multiplier inputs.
  always_comb begin
    grant_oh = '0;
    bus_io.mult_a = '0;
    bus_io.mult_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_vld && grant_id == IDW'(i)) begin
        grant_oh[i]   = 1'b1;
        bus_io.mult_a = bus_io.req_a[i*DATA_W +: DATA_W];
        bus_io.mult_b = bus_io.req_b[i*DATA_W +: DATA_W];
      end
    end
  end

  assign bus_io.req_ready     = grant_oh;
  assign bus_io.mult_valid_in = grant_vld;

  // Next-state for pointer, pending flags, held responses and the sticky error.
  always_comb begin
    rr_d       = rr_q;
    pending_d  = pending_q;
    resp_vld_d = resp_vld_q;
    resp_res_d = resp_res_q;
    err_d      = err_q;
    accept     = resp_vld_q & bus_io.resp_ready;

    // A consumed response frees its requester only from the next cycle onward,
    // so a same-cycle req_valid on that requester cannot be granted.
    resp_vld_d = resp_vld_d & ~accept;
    pending_d  = pending_d & ~accept;

    if (bus_io.mult_valid_out && tail_vld) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tail_id == IDW'(i)) begin
          resp_vld_d[i]                  = 1'b1;
          resp_res_d[i*DATA_W +: DATA_W] = bus_io.mult_result;
        end
      end
    end else if (bus_io.mult_valid_out && !tail_vld) begin
      // Unsolicited result: nothing to return it to.
      err_d = 1'b1;
    end else if (!bus_io.mult_valid_out && tail_vld) begin
      // Expected result never showed up: release the requester so it is not stuck.
      err_d = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tail_id == IDW'(i)) begin
          pending_d[i] = 1'b0;
        end
      end
    end

    pending_d = pending_d | grant_oh;

    if (grant_vld) begin
      rr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + IDW'(1);
    end
  end

  // Control and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= '0;
      pending_q  <= '0;
      resp_vld_q <= '0;
      resp_res_q <= '0;
      err_q      <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      pending_q  <= pending_d;
      resp_vld_q <= resp_vld_d;
      resp_res_q <= resp_res_d;
      err_q      <= err_d;
    end
  end

  // Tag pipe: stage 0 captures this cycle's grant, later stages shift toward the tail.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < MULT_LAT; j++) begin
        tag_vld_q[j] <= 1'b0;
        tag_id_q[j]  <= '0;
      end
    end else begin
      tag_vld_q[0] <= grant_vld;
      tag_id_q[0]  <= grant_id;
      for (int j = 1; j < MULT_LAT; j++) begin
        tag_vld_q[j] <= tag_vld_q[j-1];
        tag_id_q[j]  <= tag_id_q[j-1];
      end
    end
  end

  assign bus_io.resp_valid  = resp_vld_q;
  assign bus_io.resp_result = resp_res_q;
  assign err_seq_o          = err_q;

`ifdef FPM_ARB_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  assign cnt_d = (grant_vld && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;

  // Saturating count of issued grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 16'h0000;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`else
  assign grant_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Bench for fp_mult_arbiter: plays the requesters and a behavioural 12-bit FP
// multiplier, and keeps a transaction-level reference of pointer, outstanding
// operations and held responses.
module tb_fp_mult_arbiter;
  localparam int NR  = 4;
  localparam int DW  = 12;
  localparam int LAT = 1;

  logic        clk;
  logic        rst_n;
  logic        err_seq;
  logic [15:0] grant_cnt;

  fp_mult_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  fp_mult_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MULT_LAT(LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus_io      (bus),
    .err_seq_o   (err_seq),
    .grant_cnt_o (grant_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Behavioural 1/5/6 floating-point multiply, bias 15, truncating, saturating at 0x7B0.
  function automatic logic [DW-1:0] fpmul(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic s;
    int   e;
    logic [13:0] p;
    logic [5:0]  f;
    s = a[11] ^ b[11];
    if (a[10:6] == 5'd0 || b[10:6] == 5'd0) return 12'h000;
    if (a[10:6] == 5'd31 || b[10:6] == 5'd31) return {s, 11'h7B0};
    p = {1'b1, a[5:0]} * {1'b1, b[5:0]};
    e = int'(a[10:6]) + int'(b[10:6]) - 15;
    if (p[13]) begin e++; f = p[12:7]; end
    else f = p[11:6];
    if (e >= 31) return {s, 11'h7B0};
    if (e <= 0) return 12'h000;
    return {s, e[4:0], f};
  endfunction

  // Reference state
  typedef struct { int id; int due; logic [DW-1:0] res; } fl_t;
  fl_t         fq[$];
  int          m_rr;
  bit          m_pend[NR];
  bit          m_rv[NR];
  logic [DW-1:0] m_res[NR];
  bit          m_err;
  int          m_gcnt;
  int          cyc;
  logic [DW-1:0] opa[NR], opb[NR];

  // Multiplier model pipeline
  bit          st_v[LAT];
  logic [DW-1:0] st_d[LAT];

  // Last sampled DUT values
  logic [NR-1:0] s_ready, s_rv;
  logic [DW-1:0] s_res[NR];
  logic          s_err;
  logic [15:0]   s_gcnt;
  int            last_g;

  task automatic model_clear();
    fq.delete();
    m_rr = 0; m_err = 0; m_gcnt = 0;
    for (int i = 0; i < NR; i++) begin m_pend[i] = 0; m_rv[i] = 0; m_res[i] = '0; end
    for (int j = 0; j < LAT; j++) begin st_v[j] = 0; st_d[j] = '0; end
    bus.mult_valid_out = 1'b0;
    bus.mult_result    = '0;
  endtask

  task automatic set_op(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    opa[i] = a; opb[i] = b;
    bus.req_a[i*DW +: DW] = a;
    bus.req_b[i*DW +: DW] = b;
  endtask

  // One clock cycle: check at negedge, advance the reference, then update the
  // multiplier model just after the rising edge. frc forces mult_valid_out next
  // cycle; drp suppresses it.
  task automatic tick(input bit frc, input bit drp);
    int g;
    int tix;
    logic [NR-1:0] exp_rdy;
    logic cap_v;
    logic [DW-1:0] cap_d;
    @(negedge clk);
    g = -1;
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (m_rr + k) % NR;
      if (g < 0 && bus.req_valid[idx] && !m_pend[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    s_ready = bus.req_ready;
    s_rv    = bus.resp_valid;
    s_err   = err_seq;
    s_gcnt  = grant_cnt;
    for (int i = 0; i < NR; i++) s_res[i] = bus.resp_result[i*DW +: DW];
    check("req_ready", s_ready, exp_rdy);
    check("mult_valid_in", bus.mult_valid_in, (g >= 0));
    check("mult_a", bus.mult_a, (g >= 0) ? opa[g] : '0);
    check("mult_b", bus.mult_b, (g >= 0) ? opb[g] : '0);
    for (int i = 0; i < NR; i++) begin
      check("resp_valid", s_rv[i], m_rv[i]);
      if (m_rv[i]) check("resp_result", s_res[i], m_res[i]);
    end
    check("err_seq", s_err, m_err);
`ifdef FPM_ARB_STATS_EN
    check("grant_cnt", s_gcnt, m_gcnt);
`else
    check("grant_cnt", s_gcnt, 0);
`endif
    cap_v = bus.mult_valid_in;
    cap_d = fpmul(bus.mult_a, bus.mult_b);
    // reference update toward the next cycle
    for (int i = 0; i < NR; i++)
      if (m_rv[i] && bus.resp_ready[i]) begin m_rv[i] = 0; m_pend[i] = 0; end
    tix = -1;
    for (int q = 0; q < fq.size(); q++) if (fq[q].due == cyc + 1) tix = q;
    if (tix >= 0) begin
      if (bus.mult_valid_out) begin
        m_rv[fq[tix].id] = 1; m_res[fq[tix].id] = fq[tix].res;
      end else begin
        m_err = 1; m_pend[fq[tix].id] = 0;
      end
      fq.delete(tix);
    end else if (bus.mult_valid_out) begin
      m_err = 1;
    end
    if (g >= 0) begin
      fl_t e;
      m_pend[g] = 1;
      m_rr = (g + 1) % NR;
      e.id = g; e.due = cyc + LAT + 1; e.res = fpmul(opa[g], opb[g]);
      fq.push_back(e);
      if (m_gcnt < 65535) m_gcnt++;
    end
    last_g = g;
    @(posedge clk);
    #1;
    cyc++;
    for (int j = LAT - 1; j > 0; j--) begin st_v[j] = st_v[j-1]; st_d[j] = st_d[j-1]; end
    st_v[0] = cap_v; st_d[0] = cap_d;
    bus.mult_valid_out = (st_v[LAT-1] & ~drp) | frc;
    bus.mult_result    = st_d[LAT-1];
  endtask

  task automatic do_reset();
    bus.req_valid  = '0;
    bus.resp_ready = '0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    for (int i = 0; i < NR; i++) begin opa[i] = '0; opb[i] = '0; end
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Issue one operation on an otherwise idle arbiter and check its returned result.
  task automatic single(input int id, input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [DW-1:0] exp, input string tag);
    logic [NR-1:0] oh;
    oh = '0; oh[id] = 1'b1;
    set_op(id, a, b);
    bus.req_valid[id] = 1'b1;
    tick(0, 0);
    check({tag, "_grant"}, s_ready, oh);
    bus.req_valid[id] = 1'b0;
    for (int k = 0; k <= LAT; k++) tick(0, 0);
    check({tag, "_rvalid"}, s_rv[id], 1'b1);
    check({tag, "_result"}, s_res[id], exp);
    bus.resp_ready[id] = 1'b1;
    tick(0, 0);
    bus.resp_ready[id] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g1, oth;
    rst_n = 1'b0;
    cyc = 0;
    last_g = -1;
    do_reset();
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_err_seq", err_seq, 0);
    check("rst_grant_cnt", grant_cnt, 0);
    check("rst_mult_vin", bus.mult_valid_in, 0);

    // 1.5 * 2.0
    single(0, 12'h3E0, 12'h400, 12'h420, "t1");

    // All four at once, 1.0 * 1.0, from pointer 0
    do_reset();
    for (int i = 0; i < NR; i++) begin set_op(i, 12'h3C0, 12'h3C0); bus.req_valid[i] = 1'b1; end
    for (int k = 0; k < NR; k++) begin
      logic [NR-1:0] oh;
      oh = '0; oh[k] = 1'b1;
      tick(0, 0);
      check("t2_grant_order", s_ready, oh);
      if (last_g >= 0) bus.req_valid[last_g] = 1'b0;
    end
    for (int k = 0; k <= LAT; k++) tick(0, 0);
    for (int i = 0; i < NR; i++) check("t2_result", s_res[i], 12'h3C0);
    bus.resp_ready = '1;
    tick(0, 0);
    bus.resp_ready = '0;

    // Requester 1 holds its response; others keep flowing
    for (int i = 0; i < NR; i++) begin set_op(i, 12'h3C0 + 12'(i), 12'h400); bus.req_valid[i] = 1'b1; end
    bus.resp_ready = 4'b1101;
    g1 = 0; oth = 0;
    for (int c = 0; c < 12; c++) begin
      tick(0, 0);
      g1  += int'(s_ready[1]);
      oth += int'(s_ready[0]) + int'(s_ready[2]) + int'(s_ready[3]);
    end
    check("t3_single_grant_r1", g1, 1);
    check("t3_others_served", (oth >= 4), 1);
    bus.req_valid[0] = 1'b0; bus.req_valid[2] = 1'b0; bus.req_valid[3] = 1'b0;
    bus.resp_ready[1] = 1'b1;
    tick(0, 0);
    check("t3_no_grant_on_accept", s_ready[1], 1'b0);
    bus.resp_ready[1] = 1'b0;
    tick(0, 0);
    check("t3_grant_resumes", s_ready, 4'b0010);
    bus.req_valid[1] = 1'b0;
    bus.resp_ready = '1;
    repeat (LAT + 3) tick(0, 0);
    bus.resp_ready = '0;

    // Zero and saturation pass through
    single(2, 12'h000, 12'h3C0, 12'h000, "t4_zero");
    single(2, 12'h7C0, 12'h7C0, 12'h7B0, "t4_sat");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NR; i++)
        if (!bus.req_valid[i] && $urandom_range(0, 2) == 0) begin
          set_op(i, 12'($urandom), 12'($urandom));
          bus.req_valid[i] = 1'b1;
        end
      bus.resp_ready = NR'($urandom);
      tick(0, 0);
      if (last_g >= 0 && $urandom_range(0, 3) != 0) bus.req_valid[last_g] = 1'b0;
    end
    bus.req_valid = '0;
    bus.resp_ready = '1;
    repeat (LAT + 4) tick(0, 0);

    // Expected result missing at the tail
    set_op(0, 12'h3C0, 12'h3C0);
    bus.req_valid[0] = 1'b1;
    for (int k = 0; k < LAT; k++) begin
      tick(0, (k == LAT - 1));
      bus.req_valid[0] = 1'b0;
    end
    tick(0, 0);
    tick(0, 0);
    check("drop_err", s_err, 1'b1);
    check("drop_no_resp", s_rv[0], 1'b0);
    bus.req_valid[0] = 1'b1;
    tick(0, 0);
    check("drop_regrant", s_ready[0], 1'b1);
    bus.req_valid[0] = 1'b0;
    repeat (LAT + 3) tick(0, 0);

    // Asynchronous reset with work in flight
    bus.resp_ready = '0;
    for (int i = 0; i < 3; i++) begin set_op(i, 12'h3E0, 12'h3E0); bus.req_valid[i] = 1'b1; end
    repeat (3) begin
      tick(0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_req_ready", bus.req_ready, 0);
    check("t5_resp_valid", bus.resp_valid, 0);
    check("t5_resp_result", bus.resp_result[31:0], 0);
    check("t5_mult_vin", bus.mult_valid_in, 0);
    check("t5_mult_a", bus.mult_a, 0);
    check("t5_mult_b", bus.mult_b, 0);
    check("t5_err", err_seq, 0);
    check("t5_gcnt", grant_cnt, 0);
    model_clear();
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("t5_post_resp_valid", bus.resp_valid, 0);
    check("t5_post_err", err_seq, 0);
    repeat (3) tick(0, 0);

    // Five grants from reset
    for (int n = 0; n < 5; n++) single(n % NR, 12'h3C0, 12'h400, 12'h400, "g5");
`ifdef FPM_ARB_STATS_EN
    check("gcnt_five", s_gcnt, 5);
`else
    check("gcnt_five", s_gcnt, 0);
`endif

    // Unsolicited multiplier output
    tick(1, 0);
    tick(0, 0);
    tick(0, 0);
    check("t6_err", s_err, 1'b1);
    check("t6_no_resp", s_rv, 0);
    repeat (3) tick(0, 0);
    check("t6_err_sticky", s_err, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
